alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result bit width; all values below assume WIDTH=32.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request; sampled on a rising clk edge when ready=1.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 opcode  input  2  operation: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-009 result  output  WIDTH  registered result of the last completed operation.
REQ-010 ready  output  1  high when idle and result valid; low while an operation is in progress.
REQ-011 div_zero  output  1  high when the last completed operation was a divide with b=0.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; IDLE drives ready=1.
REQ-013 IDLE & start=1 at an edge: a, b and opcode captured into internal registers; ready=0 from the next cycle; later input changes do not affect the operation.
REQ-014 IDLE & start=0: state, result and div_zero hold.
REQ-015 start while ready=0: ignored, with no queuing.
REQ-016 Add (00): result = (a+b) mod 2^WIDTH; carry discarded; latency 1 cycle from the start edge to ready=1.
REQ-017 Subtract (01): result = (a-b) mod 2^WIDTH, two's-complement wrap; latency 1 cycle.
REQ-018 Multiply (10): iterative shift-add, one bit per cycle; result = low WIDTH bits of a*b; latency WIDTH+1 cycles.
REQ-019 Divide (11), b!=0: iterative restoring division, one quotient bit per cycle; result = floor(a/b) unsigned; remainder discarded; latency WIDTH+1 cycles.
REQ-020 Divide, b=0: no iteration; result = all ones (0xFFFFFFFF); div_zero=1; latency 1 cycle.
REQ-021 div_zero is updated at every completion: 1 only per REQ-020, otherwise 0.
REQ-022 result and div_zero update in the same edge on which ready returns to 1; neither changes at any other time.
REQ-023 Latency is fixed per opcode and independent of operand values.
REQ-024 Back-to-back operation: start may be asserted in the first cycle ready=1; the new operation is accepted then.

Reset
REQ-025 rst=1 forces immediately, regardless of clk: state IDLE, result=0, ready=1, div_zero=0, all internal registers 0.
REQ-026 rst asserted mid-operation aborts the operation; no partial result becomes visible; first start after rst deassertion is accepted normally.

Verification
REQ-027 a=10, b=20, opcode=00, start pulse -> ready=0 for 1 cycle, then result=30, div_zero=0.
REQ-028 a=50, b=15, opcode=01 -> result=35 after 1 cycle; a=0, b=1, opcode=01 -> result=0xFFFFFFFF, div_zero=0.
REQ-029 a=7, b=8, opcode=10 -> ready low exactly 33 cycles, then result=56; a=0x10000, b=0x10000 -> result=0 (truncated).
REQ-030 a=100, b=5, opcode=11 -> ready low 33 cycles, then result=20, div_zero=0.
REQ-031 a=100, b=0, opcode=11 -> after 1 cycle result=0xFFFFFFFF, div_zero=1; a following add clears div_zero to 0.
REQ-032 start multiply, assert rst at cycle 10, release, issue 10+20 add -> result=0 and ready=1 during reset, then result=30; start pulses while busy are ignored.

Source files
------------

// File: rtl/alu.sv
// Multi-cycle unsigned ALU with add, subtract, multiply and divide.
// Add, subtract and divide-by-zero finish in one cycle. Multiply (shift-add)
// and divide (restoring) each take WIDTH iteration cycles plus one
// completion cycle, whatever the operand values.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  // Multiply: a_q is the left-shifting multiplicand and b_q the
  // right-shifting multiplier. Divide: a_q is the dividend, which shifts out
  // while the quotient bits shift in; b_q holds the divisor unchanged.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Multiply: running product. Divide: partial remainder. The extra bit
  // is the borrow of the trial subtraction.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  // State and datapath registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state, iteration step and completion logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;

    // One restoring-division step: shift in the next dividend bit, then try
    // to subtract the divisor. A set top bit means the subtraction borrowed.
    rem_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = opcode;
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
          // Only multiply and a real divide need the iteration phase.
          if (opcode == OP_MUL || (opcode == OP_DIV && b != '0)) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          if (b_q[0]) begin
            acc_d = acc_q + {1'b0, a_q};
          end
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else begin
          if (!rem_diff[WIDTH]) begin
            acc_d = rem_diff;
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_shift;
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // result and div_zero change only here, on the edge back to IDLE.
        dz_d = 1'b0;
        case (op_q)
          OP_ADD: result_d = a_q + b_q;
          OP_SUB: result_d = a_q - b_q;
          OP_MUL: result_d = acc_q[WIDTH-1:0];
          default: begin
            if (b_q == '0) begin
              result_d = '1;
              dz_d     = 1'b1;
            end else begin
              result_d = a_q;
            end
          end
        endcase
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign result   = result_q;
  assign div_zero = dz_q;
  assign ready    = (state_q == IDLE);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes the expected result, div_zero and
// ready-low cycle count; the monitor pops and compares at each completion.
`timescale 1ns/1ps
module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             ready;
  logic             div_zero;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             dz;
    int               lat;
    string            name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (result),
    .ready    (ready),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Bounded wait until ready is seen high at a falling edge.
  task automatic wait_ready(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (i == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: ready still 0 after 200 cycles, want 1", name);
    end
  endtask

  // Issue one operation in the first cycle ready is high, then scramble the
  // inputs so the DUT must rely on its captured copies.
  task automatic issue(input string name, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tb, input logic [1:0] top,
                       input logic [WIDTH-1:0] eres, input logic edz,
                       input int elat);
    exp_t e;
    wait_ready(name);
    a      = ta;
    b      = tb;
    opcode = top;
    start  = 1'b1;
    e.res = eres; e.dz = edz; e.lat = elat; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    opcode = 2'($urandom_range(0, 3));
  endtask

  // Monitor: counts ready-low cycles and checks each completion.
  initial begin : monitor
    bit prev_ready;
    int low_cnt;
    exp_t e;
    prev_ready = 1'b1;
    low_cnt    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1'b1;
        low_cnt    = 0;
      end else begin
        if (!ready) begin
          low_cnt++;
        end else if (!prev_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: result 0x%08h, want no completion", result);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_div_zero"}, 32'(div_zero), 32'(e.dz));
            check({e.name, "_latency"}, 32'(low_cnt), 32'(e.lat));
            $display("done %s: result=0x%08h div_zero=%0d low_cycles=%0d",
                     e.name, result, div_zero, low_cnt);
          end
          low_cnt = 0;
        end
        prev_ready = ready;
      end
    end
  end

  initial begin : stim
    start  = 1'b0;
    a      = '0;
    b      = '0;
    opcode = 2'b00;
    rst    = 1'b1;
    #1;
    check("reset_result", result, 32'h0);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_div_zero", 32'(div_zero), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue("add_10_20",   32'd10,        32'd20,        2'b00, 32'd30,        1'b0, 1);
    issue("sub_50_15",   32'd50,        32'd15,        2'b01, 32'd35,        1'b0, 1);
    issue("sub_0_1",     32'd0,         32'd1,         2'b01, 32'hFFFFFFFF,  1'b0, 1);
    issue("add_wrap",    32'hFFFFFFFF,  32'd1,         2'b00, 32'h0,         1'b0, 1);
    issue("mul_7_8",     32'd7,         32'd8,         2'b10, 32'd56,        1'b0, 33);
    issue("mul_trunc",   32'h10000,     32'h10000,     2'b10, 32'h0,         1'b0, 33);
    issue("mul_max",     32'hFFFFFFFF,  32'hFFFFFFFF,  2'b10, 32'h1,         1'b0, 33);
    issue("mul_by_0",    32'h12345678,  32'd0,         2'b10, 32'h0,         1'b0, 33);
    issue("div_100_5",   32'd100,       32'd5,         2'b11, 32'd20,        1'b0, 33);
    issue("div_100_0",   32'd100,       32'd0,         2'b11, 32'hFFFFFFFF,  1'b1, 1);
    issue("add_clr_dz",  32'd1,         32'd2,         2'b00, 32'd3,         1'b0, 1);
    issue("div_7_9",     32'd7,         32'd9,         2'b11, 32'd0,         1'b0, 33);
    issue("div_max_1",   32'hFFFFFFFF,  32'd1,         2'b11, 32'hFFFFFFFF,  1'b0, 33);
    issue("div_1000_7",  32'd1000,      32'd7,         2'b11, 32'd142,       1'b0, 33);

    // Start pulses while busy must be ignored: only 15 comes out.
    issue("mul_busy_st", 32'd3,         32'd5,         2'b10, 32'd15,        1'b0, 33);
    repeat (3) @(negedge clk);
    a = 32'd1; b = 32'd1; opcode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Abort a multiply with reset after 10 cycles.
    issue("mul_abort",   32'd9,         32'd9,         2'b10, 32'd81,        1'b0, 33);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_result", result, 32'h0);
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_div_zero", 32'(div_zero), 32'd0);
    repeat (2) @(negedge clk);
    check("midreset_hold_result", result, 32'h0);
    rst = 1'b0;
    issue("add_after_rst", 32'd10,      32'd20,        2'b00, 32'd30,        1'b0, 1);

    wait_ready("final");
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_result_hold", result, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
